// File: rtl/div_seq4_pkg.sv
// Shared definitions for the div_seq4 sequential divider: operand width,
// counter width, state encodings and the operand word type.
package div_seq4_pkg;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N + 1);

  // Plain constants keep the encoding visible to older tools and waveform viewers.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  typedef logic [N-1:0] word_t;

endpackage

// File: rtl/div_seq4_if.sv
// Request/result bundle for div_seq4. The master issues start with A/B;
// the slave (the divider) answers with ready, done, Q, R and dbz.
interface div_seq4_if;
  import div_seq4_pkg::*;

  logic  start;
  word_t A;
  word_t B;
  logic  ready;
  logic  done;
  word_t Q;
  word_t R;
  logic  dbz;

  modport master (
    output start, A, B,
    input  ready, done, Q, R, dbz
  );

  modport slave (
    input  start, A, B,
    output ready, done, Q, R, dbz
  );

endinterface

// File: rtl/sub_rippleN.sv
// W-bit ripple-borrow subtractor: D = X - Y, Bout set when X < Y.
// Built as a chain of full-subtractor cells, LSB first.
module sub_rippleN #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic [W-1:0] D,
  output logic         Bout
);

  logic [W:0] b;

  assign b[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_cell
    // Full-subtractor cell: difference and borrow-out from X[i], Y[i], borrow-in.
    assign D[i]   = X[i] ^ Y[i] ^ b[i];
    assign b[i+1] = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & b[i]);
  end

  assign Bout = b[W];

endmodule

// File: rtl/div_seq4.sv
// Sequential restoring divider, one quotient bit per clock. Results are
// published into output registers that hold until the next result.
module div_seq4
  import div_seq4_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  div_seq4_if.slave bus
);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  div_q, div_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic [N:0]    rem_sh;
  logic [N:0]    trial;
  logic          borrow;

  // The shifted remainder never needs its top bit beyond the trial subtract.
  logic          unused_rem_msb;
  assign unused_rem_msb = rem_q[N];

  assign rem_sh = {rem_q[N-1:0], quo_q[N-1]};

  sub_rippleN #(
    .W (N + 1)
  ) u_sub (
    .X    (rem_sh),
    .Y    ({1'b0, div_q}),
    .D    (trial),
    .Bout (borrow)
  );

  // Next-state logic: operand capture, restoring step and result publication.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    div_d   = div_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          quo_d   = bus.A;
          div_d   = bus.B;
          rem_d   = '0;
          cnt_d   = CW'(N);
          state_d = (bus.B == '0) ? StFin : StRun;
        end
      end

      StRun: begin
        // Borrow means the trial went negative: keep the shifted remainder.
        rem_d = borrow ? rem_sh : trial;
        quo_d = {quo_q[N-2:0], ~borrow};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = quo_d;
          r_d     = rem_d[N-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StFin;
        end
      end

      StFin: begin
        // Arriving from RUN the result is already published (done_q set).
        // Arriving on divide-by-zero it is published here, one cycle later.
        if (!done_q) begin
          q_d    = '1;
          r_d    = quo_q;
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.done  = done_q;
  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.dbz   = dbz_q;

endmodule

// File: tb/tb_div_seq4.sv
// Scoreboard bench for div_seq4: a driver pushes expected results computed
// with plain division, a monitor pops them on each done strobe.
module tb_div_seq4;

  logic clk;
  logic rst_n;

  div_seq4_if bus ();

  div_seq4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] held_q = '0;
  logic [3:0] held_r = '0;
  logic       held_dbz = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops on done, otherwise checks outputs hold their last result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_q   = '0;
      held_r   = '0;
      held_dbz = 1'b0;
    end else if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("Q", int'(bus.Q), int'(e.q));
        chk("R", int'(bus.R), int'(e.r));
        chk("dbz", int'(bus.dbz), int'(e.dbz));
        chk("done_cycle", cyc, e.due);
        held_q   = e.q;
        held_r   = e.r;
        held_dbz = e.dbz;
      end
    end else begin
      chk("Q_hold", int'(bus.Q), int'(held_q));
      chk("R_hold", int'(bus.R), int'(held_r));
      chk("dbz_hold", int'(bus.dbz), int'(held_dbz));
    end
  end

  // Issue one division at a negedge; returns at the negedge after acceptance.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b);
    int   n = 0;
    exp_t e;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    if (b == 4'd0) begin
      e.q = 4'hF; e.r = a; e.dbz = 1'b1; e.due = cyc + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.due = cyc + 4;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.ready !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("idle_timeout", exp_q.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b0;
    #1;
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_Q", int'(bus.Q), 0);
    chk("rst_R", int'(bus.R), 0);
    chk("rst_dbz", int'(bus.dbz), 0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // 13/3 with ready profile
    do_div(4'd13, 4'd3);
    for (int i = 0; i < 5; i++) begin
      chk("ready_busy", int'(bus.ready), 0);
      @(negedge clk);
    end
    chk("ready_back", int'(bus.ready), 1);
    wait_idle();

    // 15/1 then back-to-back 2/9
    do_div(4'd15, 4'd1);
    do_div(4'd2, 4'd9);
    wait_idle();

    // divide by zero, then 9/4
    do_div(4'd7, 4'd0);
    do_div(4'd9, 4'd4);
    wait_idle();

    // starts during RUN are ignored
    do_div(4'd12, 4'd5);
    @(negedge clk);
    bus.start = 1'b1; bus.A = 4'd1; bus.B = 4'd1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // asynchronous reset mid-RUN
    do_div(4'd14, 4'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(bus.ready), 1);
    chk("midrst_Q", int'(bus.Q), 0);
    chk("midrst_R", int'(bus.R), 0);
    chk("midrst_dbz", int'(bus.dbz), 0);
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_div(4'd14, 4'd3);
    wait_idle();

    // exhaustive sweep, back to back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(a[3:0], b[3:0]);
      end
    end
    wait_idle();

    // random pairs with random idle gaps
    for (int k = 0; k < 40; k++) begin
      do_div(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
